// File: rtl/cla_share_ctrl.sv
// Shares one external 8-bit CLA slice between two requesters, sequencing multi-byte adds LSB first.
// Optional subtract support is compiled in with `define CLA_SHARE_SUB_EN.
module cla_share_ctrl #(
  parameter int NBYTES = 4,
  parameter int SETTLE = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req0_valid,
  output logic                  req0_ready,
  input  logic [8*NBYTES-1:0]   req0_a,
  input  logic [8*NBYTES-1:0]   req0_b,
  input  logic                  req0_cin,
`ifdef CLA_SHARE_SUB_EN
  input  logic                  req0_sub,
  input  logic                  req1_sub,
`endif
  input  logic                  req1_valid,
  output logic                  req1_ready,
  input  logic [8*NBYTES-1:0]   req1_a,
  input  logic [8*NBYTES-1:0]   req1_b,
  input  logic                  req1_cin,
  output logic [7:0]            cla_a,
  output logic [7:0]            cla_b,
  output logic                  cla_cin,
  input  logic [7:0]            cla_sum,
  input  logic                  cla_cout,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [8*NBYTES-1:0]   rsp_sum,
  output logic                  rsp_cout,
  output logic                  rsp_id
);

  localparam int W     = 8 * NBYTES;
  localparam int IDX_W = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam int CNT_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NBYTES - 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(SETTLE - 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_RESP} state_t;

  state_t             r_state;
  state_t             w_next;
  logic               r_rr;
  logic [IDX_W-1:0]   r_idx;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_carry;
  logic [W-1:0]       r_sum;
  logic [W-1:0]       r_a;
  logic [W-1:0]       r_b;
  logic               r_cin;
  logic               r_id;

  logic               w_any;
  logic               w_gnt;
  logic               w_accept;
  logic               w_last_cnt;
  logic               w_last_byte;
  logic [W-1:0]       w_sel_a;
  logic [W-1:0]       w_sel_b;
  logic               w_sel_cin;
  logic [W-1:0]       w_a_shift;
  logic [W-1:0]       w_b_shift;

  // Single valid requester wins outright; round-robin pointer only breaks ties.
  assign w_any       = req0_valid | req1_valid;
  assign w_gnt       = (req0_valid && req1_valid) ? r_rr : req1_valid;
  assign w_accept    = (r_state == S_IDLE) && w_any;
  assign w_last_cnt  = (r_cnt == LAST_CNT);
  assign w_last_byte = w_last_cnt && (r_idx == LAST_IDX);

  always_comb begin
    w_sel_a   = w_gnt ? req1_a : req0_a;
    w_sel_b   = w_gnt ? req1_b : req0_b;
    w_sel_cin = w_gnt ? req1_cin : req0_cin;
`ifdef CLA_SHARE_SUB_EN
    // a - b computed as a + ~b + 1; cout=1 then means no borrow.
    if (w_gnt ? req1_sub : req0_sub) begin
      w_sel_b   = ~w_sel_b;
      w_sel_cin = 1'b1;
    end
`endif
  end

  assign w_a_shift = r_a >> {r_idx, 3'b000};
  assign w_b_shift = r_b >> {r_idx, 3'b000};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (w_accept) w_next = S_RUN;
      S_RUN:   if (w_last_byte) w_next = S_RESP;
      S_RESP:  if (rsp_ready) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    cla_a      = 8'h00;
    cla_b      = 8'h00;
    cla_cin    = 1'b0;
    rsp_valid  = 1'b0;
    case (r_state)
      S_IDLE: begin
        // Gated by rst_n so both readys read 0 while reset is held.
        req0_ready = rst_n && w_any && !w_gnt;
        req1_ready = rst_n && w_any && w_gnt;
      end
      S_RUN: begin
        cla_a   = w_a_shift[7:0];
        cla_b   = w_b_shift[7:0];
        cla_cin = (r_idx == '0) ? r_cin : r_carry;
      end
      S_RESP:  rsp_valid = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rr    <= 1'b0;
      r_idx   <= '0;
      r_cnt   <= '0;
      r_carry <= 1'b0;
      r_sum   <= '0;
      r_a     <= '0;
      r_b     <= '0;
      r_cin   <= 1'b0;
      r_id    <= 1'b0;
    end else begin
      if (w_accept) begin
        r_a   <= w_sel_a;
        r_b   <= w_sel_b;
        r_cin <= w_sel_cin;
        r_id  <= w_gnt;
        r_rr  <= ~w_gnt;
        r_idx <= '0;
        r_cnt <= '0;
      end else if (r_state == S_RUN) begin
        if (w_last_cnt) begin
          r_sum[{r_idx, 3'b000} +: 8] <= cla_sum;
          r_carry <= cla_cout;
          r_cnt   <= '0;
          if (r_idx != LAST_IDX) r_idx <= r_idx + 1'b1;
        end else begin
          r_cnt <= r_cnt + 1'b1;
        end
      end
    end
  end

  assign rsp_sum  = r_sum;
  assign rsp_cout = r_carry;
  assign rsp_id   = r_id;

endmodule

// File: tb/tb_cla_share_ctrl.sv
// Directed bench for cla_share_ctrl: u0 uses SETTLE=1, u3 uses SETTLE=3 (held in reset until its test).
// Define CLA_SHARE_SUB_EN to also exercise subtraction.
module tb_cla_share_ctrl;

  logic        clk;
  logic        rst_n, rst3_n;
  logic        req0_valid, req1_valid, req0_cin, req1_cin, rsp_ready;
  logic [31:0] req0_a, req0_b, req1_a, req1_b;
`ifdef CLA_SHARE_SUB_EN
  logic        req0_sub, req1_sub;
`endif
  logic        req0_ready, req1_ready, cla_cin, rsp_valid, rsp_cout, rsp_id;
  logic [7:0]  cla_a, cla_b;
  logic [31:0] rsp_sum;
  logic [8:0]  cla_res;
  logic        r3_req0_ready, r3_req1_ready, cla3_cin, rsp3_valid, rsp3_cout, rsp3_id;
  logic [7:0]  cla3_a, cla3_b;
  logic [31:0] rsp3_sum;
  logic [8:0]  cla3_res;

  int n_checks = 0;
  int n_err    = 0;
  int seen;

  // Behavioural stand-in for the external 8-bit CLA slice.
  assign cla_res  = {1'b0, cla_a} + {1'b0, cla_b} + {8'h00, cla_cin};
  assign cla3_res = {1'b0, cla3_a} + {1'b0, cla3_b} + {8'h00, cla3_cin};

  cla_share_ctrl #(.NBYTES(4), .SETTLE(1)) u0 (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b), .req0_cin(req0_cin),
`ifdef CLA_SHARE_SUB_EN
    .req0_sub(req0_sub), .req1_sub(req1_sub),
`endif
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b), .req1_cin(req1_cin),
    .cla_a(cla_a), .cla_b(cla_b), .cla_cin(cla_cin), .cla_sum(cla_res[7:0]), .cla_cout(cla_res[8]),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_sum(rsp_sum), .rsp_cout(rsp_cout), .rsp_id(rsp_id)
  );

  cla_share_ctrl #(.NBYTES(4), .SETTLE(3)) u3 (
    .clk(clk), .rst_n(rst3_n),
    .req0_valid(req0_valid), .req0_ready(r3_req0_ready), .req0_a(req0_a), .req0_b(req0_b), .req0_cin(req0_cin),
`ifdef CLA_SHARE_SUB_EN
    .req0_sub(req0_sub), .req1_sub(req1_sub),
`endif
    .req1_valid(req1_valid), .req1_ready(r3_req1_ready), .req1_a(req1_a), .req1_b(req1_b), .req1_cin(req1_cin),
    .cla_a(cla3_a), .cla_b(cla3_b), .cla_cin(cla3_cin), .cla_sum(cla3_res[7:0]), .cla_cout(cla3_res[8]),
    .rsp_valid(rsp3_valid), .rsp_ready(rsp_ready), .rsp_sum(rsp3_sum), .rsp_cout(rsp3_cout), .rsp_id(rsp3_id)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  // Steps until u0 shows rsp_valid; an expired bound shows up as a failed check.
  task automatic wait_rsp(input string tag);
    for (int i = 0; i < 20; i++) begin
      if (rsp_valid) break;
      step();
    end
    chk(tag, rsp_valid, 1);
  endtask

  initial begin
    rst_n = 1'b0; rst3_n = 1'b0; rsp_ready = 1'b0;
    req0_valid = 1'b1; req0_a = 32'h0000_00FF; req0_b = 32'h0000_0001; req0_cin = 1'b0;
    req1_valid = 1'b0; req1_a = 32'h0; req1_b = 32'h0; req1_cin = 1'b0;
`ifdef CLA_SHARE_SUB_EN
    req0_sub = 1'b0; req1_sub = 1'b0;
`endif
    #12;
    chk("rst_ready0", req0_ready, 0);
    chk("rst_ready1", req1_ready, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_outs", {rsp_sum, rsp_cout, rsp_id, cla_a, cla_b, cla_cin}, 0);
    rst_n = 1'b1;
    #1;
    chk("post_rst_ready0", req0_ready, 1);

    // Carry ripple: 0xFF + 1
    step();
    req0_valid = 1'b0;
    chk("rip_b0", {cla_a, cla_b, cla_cin}, {8'hFF, 8'h01, 1'b0});
    chk("rip_ready_run", req0_ready, 0);
    step();
    chk("rip_b1", {cla_a, cla_b, cla_cin}, {8'h00, 8'h00, 1'b1});
    step();
    chk("rip_b2_cin", cla_cin, 0);
    step();
    chk("rip_b3_cin", cla_cin, 0);
    chk("rip_not_yet", rsp_valid, 0);
    step();
    chk("rip_valid", rsp_valid, 1);
    chk("rip_result", {rsp_sum, rsp_cout, rsp_id}, {32'h0000_0100, 1'b0, 1'b0});
    chk("resp_cla_idle", {cla_a, cla_b, cla_cin}, 0);

    // Backpressure, with req1 asking meanwhile
    req1_valid = 1'b1; req1_a = 32'hFFFF_FFFF; req1_b = 32'h0000_0001; req1_cin = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("bp_hold", {rsp_valid, rsp_sum, req0_ready, req1_ready}, {1'b1, 32'h0000_0100, 2'b00});
    end
    rsp_ready = 1'b1;
    step();
    chk("bp_release_valid", rsp_valid, 0);
    chk("bp_release_ready1", req1_ready, 1);

    // Full carry through every byte
    step();
    req1_valid = 1'b0;
    for (int i = 0; i < 4; i++) step();
    chk("full_valid", rsp_valid, 1);
    chk("full_result", {rsp_sum, rsp_cout, rsp_id}, {32'h0000_0000, 1'b1, 1'b1});
    step();

    // Round-robin from a fresh reset with both requesters valid
    rst_n = 1'b0;
    req0_valid = 1'b1; req0_a = 32'h1; req0_b = 32'h2; req0_cin = 1'b0;
    req1_valid = 1'b1; req1_a = 32'h10; req1_b = 32'h20; req1_cin = 1'b0;
    step();
    rst_n = 1'b1;
    #1;
    chk("arb_first_ready", {req0_ready, req1_ready}, 2'b10);
    for (int k = 0; k < 4; k++) begin
      wait_rsp("arb_timeout");
      chk("arb_id", rsp_id, k % 2);
      chk("arb_sum", rsp_sum, (k % 2) ? 32'h30 : 32'h3);
      if (k == 3) begin
        req0_valid = 1'b0;
        req1_valid = 1'b0;
      end
      step();
    end

    // Lone req1 wins although the tie pointer favours req0
    req1_valid = 1'b1; req1_a = 32'h100; req1_b = 32'h200; req1_cin = 1'b1;
    #1;
    chk("solo1_ready", {req0_ready, req1_ready}, 2'b01);
    step();
    req1_valid = 1'b0;
    wait_rsp("solo1_timeout");
    chk("solo1_result", {rsp_sum, rsp_id}, {32'h0000_0301, 1'b1});
    step();

    // Idle cycles leave the pointer alone; then start an op that is reset mid-run
    for (int i = 0; i < 5; i++) step();
    req0_valid = 1'b1; req0_a = 32'hAAAA_AAAA; req0_b = 32'h5555_5555; req0_cin = 1'b0;
    req1_valid = 1'b1;
    #1;
    chk("idle_ptr_ready", {req0_ready, req1_ready}, 2'b10);
    step();
    req0_valid = 1'b0; req1_valid = 1'b0;
    step();
    step();
    chk("mid_b2", {cla_a, cla_b, cla_cin}, {8'hAA, 8'h55, 1'b0});
    rst_n = 1'b0;
    #1;
    chk("mid_async_outs", {rsp_valid, rsp_sum, rsp_cout, rsp_id, cla_a, cla_b, cla_cin}, 0);
    step();
    rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      step();
      if (rsp_valid) seen++;
    end
    chk("mid_no_resp", seen, 0);
    req0_valid = 1'b1; req0_a = 32'h1234_5678; req0_b = 32'h1111_1111; req0_cin = 1'b0;
    req1_valid = 1'b1;
    #1;
    chk("mid_prio_req0", {req0_ready, req1_ready}, 2'b10);
    step();
    req0_valid = 1'b0; req1_valid = 1'b0;
    wait_rsp("mid_timeout");
    chk("mid_result", {rsp_sum, rsp_cout, rsp_id}, {32'h2345_6789, 1'b0, 1'b0});
    step();

`ifdef CLA_SHARE_SUB_EN
    // 5 - 7 wraps and borrows
    req0_valid = 1'b1; req0_sub = 1'b1; req0_a = 32'h5; req0_b = 32'h7; req0_cin = 1'b0;
    step();
    req0_valid = 1'b0; req0_sub = 1'b0;
    wait_rsp("sub_timeout");
    chk("sub_result", {rsp_sum, rsp_cout}, {32'hFFFF_FFFE, 1'b0});
    step();
`endif

    // SETTLE=3 instance: each byte held 3 cycles, latency 12
    rsp_ready = 1'b0;
    req0_valid = 1'b0;
    req1_valid = 1'b1; req1_a = 32'hFFFF_FFFF; req1_b = 32'h0000_0001; req1_cin = 1'b0;
    rst3_n = 1'b1;
    #1;
    chk("s3_ready1", r3_req1_ready, 1);
    step();
    req1_valid = 1'b0;
    for (int c = 0; c < 12; c++) begin
      chk("s3_byte", {cla3_a, cla3_b, cla3_cin, rsp3_valid},
          {8'hFF, (c < 3) ? 8'h01 : 8'h00, (c < 3) ? 1'b0 : 1'b1, 1'b0});
      step();
    end
    chk("s3_valid", rsp3_valid, 1);
    chk("s3_result", {rsp3_sum, rsp3_cout, rsp3_id}, {32'h0000_0000, 1'b1, 1'b1});

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule

// File: doc/cla_share_ctrl.md
Name: cla_share_ctrl

Overview:
- Sequencer/arbiter that shares one external 8-bit carry-lookahead adder slice between two requesters.
- Each request is a multi-byte add. The block applies the operands to the CLA slice one byte at a time, least-significant byte first, and chains the byte carry-out into the next byte's carry-in.
- Each byte is held for SETTLE cycles so the gate-delay CLA model settles before its output is sampled.
- Sits between the operand sources and the 8-bit CLA datapath. The CLA itself is not instantiated here.

Parameters:
- NBYTES, 4, operand width in bytes; operand width W = 8*NBYTES; minimum 1.
- SETTLE, 1, cycles each byte is driven before cla_sum/cla_cout are captured; minimum 1.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req0_valid  in  1  requester 0 has an operation pending.
- req0_ready  out  1  requester 0 operation accepted this cycle.
- req0_a, req0_b  in  W  requester 0 operands.
- req0_cin  in  1  requester 0 carry-in.
- req1_valid, req1_ready, req1_a, req1_b, req1_cin  same as requester 0, for requester 1.
- cla_a, cla_b  out  8  byte operands driven to the CLA slice.
- cla_cin  out  1  carry-in driven to the CLA slice.
- cla_sum  in  8  CLA sum.
- cla_cout  in  1  CLA carry-out.
- rsp_valid  out  1  result available.
- rsp_ready  in  1  consumer accepts the result.
- rsp_sum  out  W  full-width sum.
- rsp_cout  out  1  final carry-out.
- rsp_id  out  1  requester that owns the result.

Behaviour:
- Clock and reset: single clock clk; reset rst_n is asynchronous, active-low.
- Reset clears: state=IDLE, rr_ptr=0, byte index=0, settle counter=0, carry reg=0, result regs=0.
  - Outputs in reset: rsp_valid=0, rsp_sum=0, rsp_cout=0, rsp_id=0, cla_a=0, cla_b=0, cla_cin=0, req0_ready=0, req1_ready=0.
- FSM has three states: IDLE, RUN, RESP.
- IDLE, arbitration:
  - Grant goes to the single valid requester.
  - If both are valid, rr_ptr wins (0 = req0, 1 = req1).
  - reqN_ready is combinational: it is 1 only in IDLE, for the granted requester. At most one ready is high per cycle.
- IDLE, on acceptance (valid & ready at the edge):
  - Latch a, b, cin and the requester id.
  - rr_ptr <= the other requester.
  - Byte index <= 0, settle counter <= 0.
  - Go to RUN.
- RUN, datapath drive:
  - cla_a/cla_b = byte[idx] of the latched operands.
  - cla_cin = latched cin when idx=0, otherwise carry reg.
- RUN, sequencing:
  - The settle counter counts 0..SETTLE-1.
  - On the edge where the count is SETTLE-1: result byte[idx] <= cla_sum, carry reg <= cla_cout, counter <= 0.
  - If idx=NBYTES-1 go to RESP, else idx++.
- Outside RUN, cla_a/cla_b/cla_cin are driven to 0.
- Latency: rsp_valid rises exactly NBYTES*SETTLE cycles after the acceptance edge. Defaults give 4.
- RESP:
  - rsp_valid=1; rsp_sum, rsp_cout (= carry reg) and rsp_id are held stable until rsp_ready.
  - On rsp_valid & rsp_ready, go to IDLE. The next acceptance is possible in the following cycle (IDLE lasts at least one cycle).
- No acceptance in RUN or RESP: both readys are 0, and requester valids are ignored.
- rsp_sum/rsp_cout are registered and change only on capture edges.
- Boundary conditions:
  - Carry chains across all bytes: 0xFFFFFFFF + 1 gives sum 0, cout 1.
  - NBYTES=1 behaves as a single-byte operation.
  - A requester deasserting valid while it is not granted has no effect.
  - rr_ptr toggles only on acceptance, never while idle with no request.
- Reset mid-operation: the in-flight operation is dropped with no response, all registers and outputs return to their reset values immediately, and priority returns to req0.

Optional Feature:
- Macro: CLA_SHARE_SUB_EN.
- With the macro defined:
  - Ports req0_sub and req1_sub (in, 1) are added.
  - On acceptance with sub=1, the block latches b as ~b and cin as 1, ignoring reqN_cin. rsp_sum is then a - b mod 2^W, and rsp_cout=1 means no borrow.
- Without the macro: the sub ports are absent and only addition is performed.

Test Plan (NBYTES=4, SETTLE=1 unless stated):
- Reset check: hold rst_n=0 with req0_valid=1 -> every output is 0. Release reset -> req0_ready=1 in the first cycle.
- Carry ripple: req0 a=0x000000FF, b=0x00000001, cin=0 -> cla_cin is 0,1,0,0 over bytes 0..3; rsp_valid 4 cycles after acceptance; rsp_sum=0x00000100, rsp_cout=0, rsp_id=0.
- Full carry: req1 a=0xFFFFFFFF, b=0x00000001 -> rsp_sum=0x00000000, rsp_cout=1, rsp_id=1. Repeat with SETTLE=3 -> latency 12 and each cla byte held 3 cycles.
- Arbitration: both valid continuously from reset, rsp_ready=1 -> rsp_id sequence 0,1,0,1. Only req1_valid -> req1 is accepted at once regardless of rr_ptr.
- Backpressure: rsp_ready=0 for 5 cycles -> rsp_valid stays 1, rsp_sum stable, both readys 0. Releasing rsp_ready returns to IDLE next cycle.
- Mid-run reset: pulse rst_n low at idx=2 -> outputs go to 0 asynchronously and no response is issued. The next request 0x12345678 + 0x11111111 gives 0x23456789.
- With CLA_SHARE_SUB_EN: sub=1, a=5, b=7 -> rsp_sum=0xFFFFFFFE, rsp_cout=0.
